// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// Holds the FSM encoding, the grant-id type and the ALU opcode map.
package alu_arbiter_pkg;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StExec = 2'b01,
    StResp = 2'b10
  } state_e;

  localparam int unsigned GidW = 1;
  typedef logic [GidW-1:0] gid_t;

  localparam int unsigned DataW = 32;
  localparam int unsigned OpW   = 3;
  localparam int unsigned ZeroW = 3;

  localparam logic [OpW-1:0] OpAdd  = 3'b000;
  localparam logic [OpW-1:0] OpSll  = 3'b001;
  localparam logic [OpW-1:0] OpSlt  = 3'b010;
  localparam logic [OpW-1:0] OpSltu = 3'b011;
  localparam logic [OpW-1:0] OpXor  = 3'b100;
  localparam logic [OpW-1:0] OpSr   = 3'b101;
  localparam logic [OpW-1:0] OpOr   = 3'b110;
  localparam logic [OpW-1:0] OpAnd  = 3'b111;

  // One latched ALU operation.
  typedef struct packed {
    logic [DataW-1:0] a;
    logic [DataW-1:0] b;
    logic [OpW-1:0]   op;
    logic             sub;
    logic             uns;
  } alu_req_t;

  function automatic alu_req_t pack_req(input logic [DataW-1:0] a,
                                        input logic [DataW-1:0] b,
                                        input logic [OpW-1:0]   op,
                                        input logic             sub,
                                        input logic             uns);
    alu_req_t r;
    r.a   = a;
    r.b   = b;
    r.op  = op;
    r.sub = sub;
    r.uns = uns;
    return r;
  endfunction

endpackage

// File: rtl/alu_arbiter_rr_arb2.sv
// Two-way winner select: round-robin against the last grant, or fixed
// priority to requester 0.
module rr_arb2
  import alu_arbiter_pkg::*;
(
  input  logic [1:0] valid,
  input  gid_t       last,
  input  logic       fixed,
  output gid_t       winner
);

  always_comb begin
    winner = gid_t'(0);
    if (fixed) begin
      winner = valid[0] ? gid_t'(0) : gid_t'(1);
    end else if (valid == 2'b11) begin
      winner = ~last;
    end else begin
      winner = valid[1] ? gid_t'(1) : gid_t'(0);
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Arbitrates two valid/ready requesters onto one external combinational ALU
// and returns the captured result on a per-requester response handshake.
module alu_arbiter
  import alu_arbiter_pkg::*;
#(
  parameter int unsigned PRIO_FIXED = 0
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [DataW-1:0] req0_a,
  input  logic [DataW-1:0] req0_b,
  input  logic [OpW-1:0]   req0_op,
  input  logic             req0_sub,
  input  logic             req0_uns,

  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [DataW-1:0] req1_a,
  input  logic [DataW-1:0] req1_b,
  input  logic [OpW-1:0]   req1_op,
  input  logic             req1_sub,
  input  logic             req1_uns,

  output logic [DataW-1:0] alu_a,
  output logic [DataW-1:0] alu_b,
  output logic [OpW-1:0]   alu_op,
  output logic             alu_sp_sign,
  output logic             alu_uors,
  output logic [1:0]       alu_src1,
  output logic [1:0]       alu_src2,
  input  logic [DataW-1:0] alu_result,
  input  logic [ZeroW-1:0] alu_zero,

  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [DataW-1:0] rsp_result,
  output logic [ZeroW-1:0] rsp_zero
);

  state_e           state_q, state_d;
  alu_req_t         opr_q;
  gid_t             gid_q;
  gid_t             last_q;
  logic [DataW-1:0] res_q;
  logic [ZeroW-1:0] zero_q;

  gid_t             winner;
  alu_req_t         req_sel;
  logic             req_any;
  logic             rsp_fire;
  logic             accept;
  logic             capture;

  localparam logic FixedMode = (PRIO_FIXED != 0);

  rr_arb2 u_rr_arb2 (
    .valid  ({req1_valid, req0_valid}),
    .last   (last_q),
    .fixed  (FixedMode),
    .winner (winner)
  );

  assign req_any = req0_valid | req1_valid;
  assign req_sel = (winner == gid_t'(1))
                 ? pack_req(req1_a, req1_b, req1_op, req1_sub, req1_uns)
                 : pack_req(req0_a, req0_b, req0_op, req0_sub, req0_uns);
  // A ready asserted for the requester not being answered is ignored.
  assign rsp_fire = (gid_q == gid_t'(0)) ? rsp0_ready : rsp1_ready;

  // FSM: state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req_any) state_d = StExec;
      StExec:  state_d = StResp;
      StResp:  if (rsp_fire) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // FSM: outputs. Gated by rst so handshakes drop the instant reset rises.
  always_comb begin
    req0_ready = 1'b0;
    req1_ready = 1'b0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    accept     = 1'b0;
    capture    = 1'b0;
    if (!rst) begin
      case (state_q)
        StIdle: begin
          accept     = req_any;
          req0_ready = req0_valid && (winner == gid_t'(0));
          req1_ready = req1_valid && (winner == gid_t'(1));
        end
        StExec: capture = 1'b1;
        StResp: begin
          rsp0_valid = (gid_q == gid_t'(0));
          rsp1_valid = (gid_q == gid_t'(1));
        end
        default: ;
      endcase
    end
  end

  // Operand, grant and result registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      opr_q  <= '0;
      gid_q  <= gid_t'(0);
      last_q <= gid_t'(1);
      res_q  <= '0;
      zero_q <= '0;
    end else begin
      if (accept) begin
        opr_q  <= req_sel;
        gid_q  <= winner;
        last_q <= winner;
      end
      if (capture) begin
        res_q  <= alu_result;
        zero_q <= alu_zero;
      end
    end
  end

  // The ALU only ever sees latched operands, so requesters may change freely.
  assign alu_a       = opr_q.a;
  assign alu_b       = opr_q.b;
  assign alu_op      = opr_q.op;
  assign alu_sp_sign = opr_q.sub;
  assign alu_uors    = opr_q.uns;
  assign alu_src1    = 2'b00;
  assign alu_src2    = 2'b00;

  assign rsp_result  = res_q;
  assign rsp_zero    = zero_q;

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with an external ALU model and a response scoreboard.
// A second instance in fixed-priority mode shares the request stimulus.
module tb_alu_arbiter;
  import alu_arbiter_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        req0_valid, req1_valid;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic [2:0]  req0_op, req1_op;
  logic        req0_sub, req1_sub, req0_uns, req1_uns;
  logic        rsp0_ready, rsp1_ready;

  logic        req0_ready, req1_ready, rsp0_valid, rsp1_valid;
  logic [31:0] alu_a, alu_b, alu_result, rsp_result;
  logic [2:0]  alu_op, alu_zero, rsp_zero;
  logic        alu_sp_sign, alu_uors;
  logic [1:0]  alu_src1, alu_src2;

  logic        fx_req0_ready, fx_req1_ready, fx_rsp0_valid, fx_rsp1_valid;
  logic [31:0] fx_alu_a, fx_alu_b, fx_alu_result, fx_rsp_result;
  logic [2:0]  fx_alu_op, fx_alu_zero, fx_rsp_zero;
  logic        fx_alu_sp_sign, fx_alu_uors;
  logic [1:0]  fx_alu_src1, fx_alu_src2;
  logic        fx_rsp_ready = 1'b1;

  typedef struct {
    logic        gid;
    logic [31:0] res;
    logic [2:0]  zero;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_fail = 0;
  int   n_done = 0;
  int   fx_grants = 0;

  function automatic logic [31:0] alu_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [2:0] op, input logic sub,
                                         input logic uns);
    case (op)
      3'b000:  return sub ? a - b : a + b;
      3'b001:  return a << b[4:0];
      3'b010:  return uns ? {31'b0, a < b} : {31'b0, $signed(a) < $signed(b)};
      3'b011:  return {31'b0, a < b};
      3'b100:  return a ^ b;
      3'b101:  return sub ? $unsigned($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'b110:  return a | b;
      default: return a & b;
    endcase
  endfunction

  function automatic logic [2:0] zero_fn(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] r);
    return {r == 32'd0, $signed(a) < $signed(b), a < b};
  endfunction

  always_comb begin
    alu_result    = alu_fn(alu_a, alu_b, alu_op, alu_sp_sign, alu_uors);
    alu_zero      = zero_fn(alu_a, alu_b, alu_result);
    fx_alu_result = alu_fn(fx_alu_a, fx_alu_b, fx_alu_op, fx_alu_sp_sign, fx_alu_uors);
    fx_alu_zero   = zero_fn(fx_alu_a, fx_alu_b, fx_alu_result);
  end

  alu_arbiter #(.PRIO_FIXED(0)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_sub(req0_sub), .req0_uns(req0_uns),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_sub(req1_sub), .req1_uns(req1_uns),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .alu_sp_sign(alu_sp_sign),
    .alu_uors(alu_uors), .alu_src1(alu_src1), .alu_src2(alu_src2),
    .alu_result(alu_result), .alu_zero(alu_zero),
    .rsp0_valid(rsp0_valid), .rsp0_ready(rsp0_ready),
    .rsp1_valid(rsp1_valid), .rsp1_ready(rsp1_ready),
    .rsp_result(rsp_result), .rsp_zero(rsp_zero)
  );

  alu_arbiter #(.PRIO_FIXED(1)) dut_fx (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(fx_req0_ready), .req0_a(req0_a), .req0_b(req0_b),
    .req0_op(req0_op), .req0_sub(req0_sub), .req0_uns(req0_uns),
    .req1_valid(req1_valid), .req1_ready(fx_req1_ready), .req1_a(req1_a), .req1_b(req1_b),
    .req1_op(req1_op), .req1_sub(req1_sub), .req1_uns(req1_uns),
    .alu_a(fx_alu_a), .alu_b(fx_alu_b), .alu_op(fx_alu_op), .alu_sp_sign(fx_alu_sp_sign),
    .alu_uors(fx_alu_uors), .alu_src1(fx_alu_src1), .alu_src2(fx_alu_src2),
    .alu_result(fx_alu_result), .alu_zero(fx_alu_zero),
    .rsp0_valid(fx_rsp0_valid), .rsp0_ready(fx_rsp_ready),
    .rsp1_valid(fx_rsp1_valid), .rsp1_ready(fx_rsp_ready),
    .rsp_result(fx_rsp_result), .rsp_zero(fx_rsp_zero)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Response side of the scoreboard, plus the fixed-priority watch.
  always @(negedge clk) begin
    if (!rst && (rsp0_valid || rsp1_valid)) begin
      if (sb.size() == 0) begin
        chk("rsp_without_txn", {31'b0, rsp0_valid | rsp1_valid}, 32'd0);
      end else begin
        chk("rsp0_valid", {31'b0, rsp0_valid}, {31'b0, sb[0].gid == 1'b0});
        chk("rsp1_valid", {31'b0, rsp1_valid}, {31'b0, sb[0].gid == 1'b1});
        chk("rsp_result", rsp_result, sb[0].res);
        chk("rsp_zero", {29'b0, rsp_zero}, {29'b0, sb[0].zero});
        if ((sb[0].gid == 1'b0 && rsp0_ready) || (sb[0].gid == 1'b1 && rsp1_ready)) begin
          void'(sb.pop_front());
          n_done++;
        end
      end
    end
    if (!rst && req0_valid) chk("fx_req1_ready", {31'b0, fx_req1_ready}, 32'd0);
    if (!rst && fx_req0_ready) fx_grants++;
  end

  // Called at posedge+1 with requests already driven and the DUT idle.
  task automatic do_txn(input logic gid, input logic [31:0] res, input logic [2:0] z,
                        input int lat, input string tag);
    int n;
    sb.push_back('{gid, res, z});
    #1;
    chk({tag, "_req0_ready"}, {31'b0, req0_ready}, {31'b0, gid == 1'b0});
    chk({tag, "_req1_ready"}, {31'b0, req1_ready}, {31'b0, gid == 1'b1});
    @(posedge clk); #1;
    chk({tag, "_exec_ready"}, {30'b0, req0_ready, req1_ready}, 32'd0);
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk({tag, "_latency"}, n, lat);
  endtask

  task automatic set_req0(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic sub, input logic uns);
    req0_a = a; req0_b = b; req0_op = op; req0_sub = sub; req0_uns = uns;
  endtask

  task automatic set_req1(input logic [31:0] a, input logic [31:0] b, input logic [2:0] op,
                          input logic sub, input logic uns);
    req1_a = a; req1_b = b; req1_op = op; req1_sub = sub; req1_uns = uns;
  endtask

  initial begin
    int fx_base;
    int done_base;
    rst = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    set_req0(32'h11, 32'h22, 3'b110, 1'b0, 1'b0);
    set_req1(32'h33, 32'h44, 3'b100, 1'b0, 1'b0);
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;

    // Reset state
    #1;
    chk("rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    chk("rst_req1_ready", {31'b0, req1_ready}, 32'd0);
    chk("rst_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    chk("rst_alu_a", alu_a, 32'd0);
    chk("rst_alu_op", {29'b0, alu_op}, 32'd0);
    chk("rst_alu_src", {28'b0, alu_src1, alu_src2}, 32'd0);
    chk("rst_rsp_result", rsp_result, 32'd0);
    @(posedge clk); @(posedge clk); #1;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // Round-robin with both requesters continuously valid
    set_req0(32'h7, 32'h9, 3'b100, 1'b0, 1'b0);
    set_req1(32'hF0, 32'h3C, 3'b111, 1'b0, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    fx_base = fx_grants;
    do_txn(1'b0, 32'hE, 3'b011, 2, "rr0");
    do_txn(1'b1, 32'h30, 3'b000, 2, "rr1");
    do_txn(1'b0, 32'hE, 3'b011, 2, "rr2");
    do_txn(1'b1, 32'h30, 3'b000, 2, "rr3");
    chk("fx_req0_grants", fx_grants - fx_base, 32'd4);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;

    // Single request
    set_req0(32'd5, 32'd3, 3'b000, 1'b1, 1'b0);
    req0_valid = 1'b1;
    do_txn(1'b0, 32'd2, 3'b000, 2, "single");

    // Unsigned vs signed compare
    set_req0(32'hFFFF_FFFF, 32'd1, 3'b011, 1'b0, 1'b1);
    do_txn(1'b0, 32'd0, 3'b110, 2, "sltu");
    set_req0(32'hFFFF_FFFF, 32'd1, 3'b010, 1'b0, 1'b0);
    do_txn(1'b0, 32'd1, 3'b010, 2, "slt");

    // Back-pressure with a competing requester and changing req0 inputs
    rsp0_ready = 1'b0;
    set_req0(32'd100, 32'd1, 3'b000, 1'b0, 1'b0);
    sb.push_back('{1'b0, 32'd101, 3'b000});
    done_base = n_done;
    #1;
    chk("bp_accept_ready", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    req1_valid = 1'b1;
    set_req0(32'd999, 32'd7, 3'b110, 1'b1, 1'b1);
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      chk("bp_req1_ready", {31'b0, req1_ready}, 32'd0);
      chk("bp_rsp0_valid", {31'b0, rsp0_valid}, 32'd1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    rsp0_ready = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("bp_completions", n_done - done_base, 32'd1);
    chk("bp_sb_empty", sb.size(), 32'd0);

    // Reset in EXEC: last grant was 0, so only a reset makes req0 win the next tie
    set_req0(32'd1, 32'd2, 3'b000, 1'b0, 1'b0);
    req0_valid = 1'b1;
    #1;
    chk("mid_accept_ready", {31'b0, req0_ready}, 32'd1);
    @(posedge clk); #1;
    chk("mid_exec_alu_a", alu_a, 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_alu_a", alu_a, 32'd0);
    chk("mid_rst_alu_b", alu_b, 32'd0);
    chk("mid_rst_req0_ready", {31'b0, req0_ready}, 32'd0);
    chk("mid_rst_rsp_valid", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    req0_valid = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    chk("mid_no_rsp", {30'b0, rsp0_valid, rsp1_valid}, 32'd0);
    set_req0(32'd8, 32'd8, 3'b000, 1'b1, 1'b0);
    set_req1(32'd3, 32'd4, 3'b110, 1'b0, 1'b0);
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    do_txn(1'b0, 32'd0, 3'b100, 2, "post_rst");
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    @(posedge clk); #1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter PRIO_FIXED, default 0, meaning 0 = round-robin arbitration and 1 = requester 0 always wins.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst, input, 1 bit, asynchronous active-high reset.
REQ-004 SHALL have ports reqN_valid (input, 1) and reqN_ready (output, 1) for N = 0,1, forming a valid/ready request handshake.
REQ-005 SHALL have ports reqN_a and reqN_b (input, 32 each) for N = 0,1, carrying the operands.
REQ-006 SHALL have ports reqN_op (input, 3), reqN_sub (input, 1) and reqN_uns (input, 1) for N = 0,1, carrying the ALU opcode, sub/arith-shift flag and unsigned-compare flag.
REQ-007 SHALL have ports alu_a and alu_b (output, 32 each), alu_op (output, 3), alu_sp_sign (output, 1) and alu_uors (output, 1), which drive the shared ALU.
REQ-008 SHALL have ports alu_src1 and alu_src2 (output, 2 each), tied to 2'b00 so the ALU selects register operands.
REQ-009 SHALL have ports alu_result (input, 32) and alu_zero (input, 3), which return the ALU outputs combinationally.
REQ-010 SHALL have ports rspN_valid (output, 1) and rspN_ready (input, 1) for N = 0,1, forming a per-requester response handshake.
REQ-011 SHALL have ports rsp_result (output, 32) and rsp_zero (output, 3), shared response data valid whenever any rspN_valid is high.

Function
REQ-012 SHALL implement the FSM states IDLE, EXEC and RESP, encoded in 2 bits.
REQ-013 In IDLE with at least one reqN_valid high, SHALL assert reqN_ready for exactly one granted requester in the same cycle, latch its a/b/op/sub/uns and grant id, and move to EXEC.
REQ-014 reqN_ready SHALL be combinational: high only when state == IDLE, reqN_valid is high and N is the winner; it SHALL be 0 in EXEC and RESP.
REQ-015 In round-robin mode, when both requesters are valid the winner SHALL be the one not recorded in last_grant; a lone valid requester SHALL always win.
REQ-016 last_grant SHALL update only at the acceptance edge.
REQ-017 In fixed mode, requester 0 SHALL win whenever req0_valid is high.
REQ-018 alu_* outputs SHALL be driven from the latched operand registers in every state, never directly from the reqN ports.
REQ-019 In EXEC, SHALL capture alu_result and alu_zero into the result registers and move to RESP.
REQ-020 In RESP, rspN_valid SHALL be high only for the granted id, and rsp_result/rsp_zero SHALL hold stable until the handshake completes.
REQ-021 In RESP, when rspN_valid and rspN_ready are both high, SHALL return to IDLE on that edge; a new request is accepted no earlier than the following cycle.
REQ-022 Latency SHALL be: accept edge T, result captured at T+1, rspN_valid high during cycle T+1 to T+2; minimum issue interval 3 cycles.
REQ-023 While rspN_ready is held low, SHALL stay in RESP indefinitely and SHALL not accept any request (back-pressure).
REQ-024 Request inputs changing after acceptance SHALL have no effect on the operation in flight.
REQ-025 rspN_ready asserted while rspN_valid is low SHALL be ignored.

Reset
REQ-026 rst high SHALL, asynchronously, set state to IDLE, last_grant to 1 (so requester 0 wins the first tie), and all operand/result registers and alu_* outputs to 0.
REQ-027 rst high SHALL, asynchronously, force all reqN_ready and rspN_valid outputs to 0.
REQ-028 rst asserted during EXEC or RESP SHALL abort the operation with no response issued.

Structure
REQ-029 The state encoding, the grant-id width (1) and the ALU opcode constants (ADD = 000 through AND = 111) SHALL reside in a shared package.
REQ-030 The round-robin/fixed winner logic SHALL be one sub-module, rr_arb2 (inputs: valid[1:0], last, fixed; output: winner).
REQ-031 The ALU itself SHALL stay external, not instantiated inside this block.

Verification
REQ-032 Single request: req0 {a=5, b=3, op=000, sub=1} -> rsp0_valid 2 cycles later, rsp_result=2, rsp1_valid=0.
REQ-033 Simultaneous request, round-robin: both valid every cycle -> grants follow the order 0,1,0,1 and each rsp carries its own result (req1 AND 0xF0&0x3C=0x30).
REQ-034 Fixed priority: PRIO_FIXED=1, both valid continuously -> req1_ready never asserts while req0_valid is high.
REQ-035 Back-pressure: rsp0_ready held low for 10 cycles -> rsp0_valid and rsp_result stay stable, req1_ready stays 0, then exactly one completion.
REQ-036 SLTU compare: a=0xFFFFFFFF, b=1, op=011, uns=1 -> rsp_result=0; the same operands with op=010 -> rsp_result=1.
REQ-037 Mid-flight reset: rst pulsed in EXEC -> all outputs 0 immediately, no rsp_valid afterwards, and req0 wins the next tie.
